// File: rtl/binary_row_profiler_pkg.sv
// rtl/binary_row_profiler_pkg.sv - shared constants for the binarizer / row profiler pair
package binary_row_profiler_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int PIX_W  = 8;
    // Offset 0 is the leftmost bit of each byte in the ascending-indexed bus, i.e. its MSB.
    localparam int FG_BIT = 0;

    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int tw_of(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/binary_row_profiler.sv
// rtl/binary_row_profiler.sv - captures a binarized frame and streams per-row foreground profiles
module binary_row_profiler
    import binary_row_profiler_pkg::*;
#(
    parameter int width     = 10,
    parameter int height    = 10,
    parameter int min_count = 2,
    parameter int CW        = cw_of(width),
    parameter int TW        = tw_of(width, height)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [0:width*height*PIX_W-1]     frame_in,
    input  logic                              frame_valid,
    output logic                              frame_ready,
    output logic                              row_valid,
    input  logic                              row_ready,
    output logic [((height > 1) ? $clog2(height) : 1)-1:0] row_index,
    output logic [0:width-1]                  row_bits,
    output logic [CW-1:0]                     row_count,
    output logic                              row_is_text,
    output logic                              row_last,
    output logic                              frame_done,
    output logic [TW-1:0]                     frame_total
);

    localparam int NPIX = width * height;
    localparam int PW   = $clog2(NPIX);
    localparam int RW   = (height > 1) ? $clog2(height) : 1;
    localparam int COLW = (width > 1) ? $clog2(width) : 1;

    logic [1:0]      state;
    logic [0:NPIX-1] fg_in;
    logic [0:NPIX-1] fg_buf;
    logic [RW-1:0]   row;
    logic [COLW-1:0] col;
    logic [0:width-1] acc_bits;
    logic [CW-1:0]   acc_count;
    logic [TW-1:0]   total_acc;
    logic [PW-1:0]   pix_idx;
    logic            fg;
    logic [0:width-1] bits_nxt;
    logic [CW-1:0]   count_nxt;

    // Only the foreground flag of each byte is kept; the remaining bits feed nothing.
    logic unused_frame_bits;
    assign unused_frame_bits = ^frame_in;

    for (genvar p = 0; p < NPIX; p++) begin : g_fg
        assign fg_in[p] = frame_in[p*PIX_W + FG_BIT];
    end

    assign pix_idx   = PW'(row) * PW'(width) + PW'(col);
    assign fg        = fg_buf[pix_idx];
    assign count_nxt = acc_count + CW'(fg);

    always_comb begin
        bits_nxt      = acc_bits;
        bits_nxt[col] = fg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            frame_ready <= 1'b0;
            row         <= '0;
            col         <= '0;
            acc_bits    <= '0;
            acc_count   <= '0;
            total_acc   <= '0;
            row_valid   <= 1'b0;
            row_index   <= '0;
            row_bits    <= '0;
            row_count   <= '0;
            row_is_text <= 1'b0;
            row_last    <= 1'b0;
            frame_done  <= 1'b0;
            frame_total <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    frame_ready <= 1'b1;
                    if (frame_valid && frame_ready) begin
                        fg_buf      <= fg_in;
                        row         <= '0;
                        col         <= '0;
                        acc_bits    <= '0;
                        acc_count   <= '0;
                        total_acc   <= '0;
                        frame_ready <= 1'b0;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    acc_bits  <= bits_nxt;
                    acc_count <= count_nxt;
                    col       <= col + 1'b1;
                    if (col == COLW'(width - 1)) begin
                        row_index   <= row;
                        row_bits    <= bits_nxt;
                        row_count   <= count_nxt;
                        row_is_text <= (count_nxt >= CW'(min_count));
                        row_last    <= (row == RW'(height - 1));
                        total_acc   <= total_acc + TW'(count_nxt);
                        row_valid   <= 1'b1;
                        state       <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (row_ready) begin
                        row_valid <= 1'b0;
                        if (row_last) begin
                            frame_done  <= 1'b1;
                            frame_total <= total_acc;
                            state       <= S_DONE;
                        end else begin
                            row       <= row + 1'b1;
                            col       <= '0;
                            acc_bits  <= '0;
                            acc_count <= '0;
                            state     <= S_SCAN;
                        end
                    end
                end
                default: begin
                    frame_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_row_profiler.sv
// tb/tb_binary_row_profiler.sv - randomized self-checking bench for binary_row_profiler
module tb_binary_row_profiler;

    localparam int W    = 10;
    localparam int H    = 10;
    localparam int NP   = W * H;
    localparam int MINC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [0:NP*8-1]  frame_in;
    logic             frame_valid;
    logic             frame_ready;
    logic             row_valid;
    logic             row_ready;
    logic [3:0]       row_index;
    logic [0:W-1]     row_bits;
    logic [3:0]       row_count;
    logic             row_is_text;
    logic             row_last;
    logic             frame_done;
    logic [6:0]       frame_total;

    always #5 clk = ~clk;

    binary_row_profiler #(.width(W), .height(H), .min_count(MINC)) dut (
        .clk(clk), .rst(rst),
        .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .row_valid(row_valid), .row_ready(row_ready), .row_index(row_index),
        .row_bits(row_bits), .row_count(row_count), .row_is_text(row_is_text),
        .row_last(row_last), .frame_done(frame_done), .frame_total(frame_total)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]   pix [NP];
    logic [7:0]   pix2[NP];
    logic [0:W-1] eb  [H];
    int           ec  [H];
    int           etot;
    int           want_t0   = -1;
    int           last_done = 0;

    // Reference: foreground means byte value >= 0x80.
    task automatic build_model();
        etot = 0;
        for (int r = 0; r < H; r++) begin
            eb[r] = '0;
            ec[r] = 0;
            for (int c = 0; c < W; c++) begin
                if (pix[r*W+c] >= 8'h80) begin
                    eb[r][c] = 1'b1;
                    ec[r]++;
                end
            end
            etot += ec[r];
        end
    endtask

    function automatic logic [7:0] rand_byte(input int dens);
        if ($urandom_range(0, 3) < dens) return 8'($urandom_range(128, 255));
        return 8'($urandom_range(0, 127));
    endfunction

    task automatic rand_frames();
        for (int r = 0; r < H; r++) begin
            int d1 = $urandom_range(0, 4);
            int d2 = $urandom_range(0, 4);
            for (int c = 0; c < W; c++) begin
                pix[r*W+c]  = rand_byte(d1);
                pix2[r*W+c] = rand_byte(d2);
            end
        end
    endtask

    task automatic check_zero();
        check("rst_frame_ready", frame_ready, 0);
        check("rst_row_valid",   row_valid,   0);
        check("rst_row_index",   row_index,   0);
        check("rst_row_bits",    row_bits,    0);
        check("rst_row_count",   row_count,   0);
        check("rst_row_is_text", row_is_text, 0);
        check("rst_row_last",    row_last,    0);
        check("rst_frame_done",  frame_done,  0);
        check("rst_frame_total", frame_total, 0);
    endtask

    task automatic run_frame(input int bp_row, input bit keep_valid);
        int n;
        int t0;
        int hs;
        logic [0:W-1] hold_bits;
        build_model();
        for (int p = 0; p < NP; p++) frame_in[8*p +: 8] = pix[p];
        frame_valid = 1'b1;
        row_ready   = 1'b1;
        n = 0;
        while (!frame_ready && n < 300) begin @(negedge clk); n++; end
        if (!frame_ready) begin
            check("accept_timeout", 0, 1);
            frame_valid = 1'b0;
            return;
        end
        t0 = cyc + 1;
        if (want_t0 >= 0) check("accept_cycle", t0, want_t0);
        @(negedge clk);
        if (keep_valid) for (int p = 0; p < NP; p++) frame_in[8*p +: 8] = pix2[p];
        else frame_valid = 1'b0;
        check("ready_low_scan", frame_ready, 0);
        hs = t0;
        for (int r = 0; r < H; r++) begin
            row_ready = (r != bp_row);
            n = 0;
            while (!row_valid && n < 40) begin @(negedge clk); n++; end
            if (!row_valid) begin
                check("row_valid_timeout", 0, 1);
                row_ready = 1'b1;
                return;
            end
            check("row_latency", cyc - hs, W);
            check("row_index",   row_index,   r);
            check("row_bits",    row_bits,    eb[r]);
            check("row_count",   row_count,   ec[r]);
            check("row_is_text", row_is_text, ec[r] >= MINC);
            check("row_last",    row_last,    r == H - 1);
            if (r == bp_row) begin
                hold_bits = row_bits;
                for (int k = 0; k < 5; k++) begin
                    frame_valid = 1'b1;
                    for (int p = 0; p < NP; p++) frame_in[8*p +: 8] = 8'($urandom);
                    @(negedge clk);
                    check("bp_valid_held", row_valid,   1);
                    check("bp_index_held", row_index,   r);
                    check("bp_bits_held",  row_bits,    hold_bits);
                    check("bp_count_held", row_count,   ec[r]);
                    check("bp_not_ready",  frame_ready, 0);
                end
                frame_valid = 1'b0;
                row_ready   = 1'b1;
            end
            hs = cyc + 1;
            @(negedge clk);
            if (r < H - 1) check("valid_drop", row_valid, 0);
        end
        check("frame_done_pulse", frame_done,  1);
        check("frame_total",      frame_total, etot);
        if (bp_row < 0) check("frame_time", cyc - t0, 1 + H*(W+1) - 1);
        last_done = cyc;
        @(negedge clk);
        check("frame_done_single", frame_done,  0);
        check("ready_after_done",  frame_ready, 1);
        check("frame_total_held",  frame_total, etot);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int seen;
        rst         = 1'b1;
        frame_valid = 1'b0;
        row_ready   = 1'b1;
        frame_in    = '0;
        repeat (2) @(negedge clk);
        check_zero();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", frame_ready, 1);

        for (int p = 0; p < NP; p++) pix[p] = 8'h00;
        run_frame(-1, 1'b0);

        for (int p = 0; p < NP; p++) pix[p] = 8'h00;
        for (int c = 0; c < W; c++) begin
            pix[4*W+c] = 8'hFF;
            pix[5*W+c] = 8'hFF;
        end
        pix[7*W+2] = 8'hFF;
        run_frame(-1, 1'b0);
        check("band_total_const", etot, 21);

        for (int p = 0; p < NP; p++) pix[p] = 8'h00;
        pix[0]     = 8'h80;
        pix[1]     = 8'h7F;
        pix[W]     = 8'hC3;
        pix[W+W-1] = 8'h81;
        run_frame(-1, 1'b0);

        rand_frames();
        run_frame(2, 1'b0);

        // Reset in the middle of row 3's scan.
        rand_frames();
        for (int p = 0; p < NP; p++) frame_in[8*p +: 8] = pix[p];
        frame_valid = 1'b1;
        seen = 0;
        while (!frame_ready && seen < 50) begin @(negedge clk); seen++; end
        t0 = cyc + 1;
        @(negedge clk);
        frame_valid = 1'b0;
        while (cyc < t0 + 37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", frame_ready, 1);
        check("valid_after_midreset", row_valid,   0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (row_valid || frame_done) seen++;
        end
        check("no_rows_after_reset", seen, 0);

        rand_frames();
        run_frame(-1, 1'b1);
        for (int p = 0; p < NP; p++) pix[p] = pix2[p];
        want_t0 = last_done + 2;
        run_frame(-1, 1'b0);
        want_t0 = -1;

        for (int i = 0; i < 4; i++) begin
            rand_frames();
            run_frame((i % 2 == 0) ? -1 : int'($urandom_range(0, H-1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
